// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_pkg
//  Description : Shared constants and helpers for the instruction-fetch stage
//                and the fetch/decode pipeline latch.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

  localparam int PC_WIDTH   = 12;
  localparam int INST_WIDTH = 32;

  localparam logic [PC_WIDTH-1:0]   RESET_PC = '0;
  localparam logic [INST_WIDTH-1:0] NOP_INST = '0;

  // Sequential successor of a PC; wraps naturally at 2^PC_WIDTH.
  function automatic logic [PC_WIDTH-1:0] pc_inc(input logic [PC_WIDTH-1:0] pc);
    return pc + {{(PC_WIDTH-1){1'b0}}, 1'b1};
  endfunction

endpackage : fetch_unit_pkg
`default_nettype wire

// File: rtl/fetch_hold_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_hold_buffer
//  Description : One-entry buffer that parks the in-flight instruction/PC
//                when the downstream latch stalls, so no response is lost.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_hold_buffer
  import fetch_unit_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  capture_i,
  input  logic                  release_i,
  input  logic                  flush_i,
  input  logic [INST_WIDTH-1:0] inst_i,
  input  logic [PC_WIDTH-1:0]   pc_i,
  output logic [INST_WIDTH-1:0] inst_o,
  output logic [PC_WIDTH-1:0]   pc_o,
  output logic                  valid_o
);

  logic [INST_WIDTH-1:0] holdInst_q;
  logic [PC_WIDTH-1:0]   holdPc_q;
  logic                  holdValid_q;

  // Buffer register: reset > flush > capture > release.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      holdInst_q  <= '0;
      holdPc_q    <= '0;
      holdValid_q <= 1'b0;
    end else if (flush_i) begin
      holdValid_q <= 1'b0;
    end else if (capture_i) begin
      holdInst_q  <= inst_i;
      holdPc_q    <= pc_i;
      holdValid_q <= 1'b1;
    end else if (release_i) begin
      holdValid_q <= 1'b0;
    end
  end

  assign inst_o  = holdInst_q;
  assign pc_o    = holdPc_q;
  assign valid_o = holdValid_q;

endmodule : fetch_hold_buffer
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction-fetch stage. Owns the PC, drives a one-cycle
//                latency instruction memory, absorbs stalls through a hold
//                buffer and applies redirects with a two-bubble penalty.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  stall_i,
  input  logic                  redirect_i,
  input  logic [PC_WIDTH-1:0]   redirectPc_i,
  output logic [PC_WIDTH-1:0]   imemAddr_o,
  input  logic [INST_WIDTH-1:0] imemData_i,
  output logic [INST_WIDTH-1:0] inst_o,
  output logic [PC_WIDTH-1:0]   seqNextPc_o,
  output logic                  fetchValid_o
);

  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [PC_WIDTH-1:0]   respPc_q, respPc_d;
  logic                  respValid_q, respValid_d;

  logic [INST_WIDTH-1:0] holdInst;
  logic [PC_WIDTH-1:0]   holdPc;
  logic                  holdValid;

  logic                  advance;
  logic                  capture;
  logic                  release_hold;
  logic [PC_WIDTH-1:0]   outPc;
  logic [INST_WIDTH-1:0] selInst;

  // The pipeline only freezes when it actually has something to protect.
  assign advance      = !(stall_i && (holdValid || respValid_q));
  // A redirect flushes the buffer, so capture is suppressed under redirect.
  assign capture      = respValid_q && stall_i && !holdValid && !redirect_i;
  assign release_hold = holdValid && !stall_i;

  fetch_hold_buffer u_hold (
    .clk_i     (clock_i),
    .rst_i     (reset_i),
    .capture_i (capture),
    .release_i (release_hold),
    .flush_i   (redirect_i),
    .inst_i    (imemData_i),
    .pc_i      (respPc_q),
    .inst_o    (holdInst),
    .pc_o      (holdPc),
    .valid_o   (holdValid)
  );

  // Next-state for PC and response tracking: redirect beats stall/advance.
  always_comb begin
    pc_d        = pc_q;
    respPc_d    = respPc_q;
    respValid_d = 1'b0;
    if (redirect_i) begin
      pc_d        = redirectPc_i;
      respValid_d = 1'b0;
    end else if (advance) begin
      respPc_d    = pc_q;
      respValid_d = 1'b1;
      pc_d        = pc_inc(pc_q);
    end
  end

  // PC and response-tracking registers.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      pc_q        <= RESET_PC;
      respPc_q    <= '0;
      respValid_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      respPc_q    <= respPc_d;
      respValid_q <= respValid_d;
    end
  end

  // Output select: the held entry is older than the live response, so it
  // goes first. Reset also masks validity so stale state never leaks out.
  assign outPc        = holdValid ? holdPc   : respPc_q;
  assign selInst      = holdValid ? holdInst : imemData_i;
  assign fetchValid_o = (holdValid || respValid_q) && !redirect_i && !reset_i;
  assign inst_o       = fetchValid_o ? selInst : NOP_INST;
  assign seqNextPc_o  = pc_inc(outPc);
  assign imemAddr_o   = pc_q;

endmodule : fetch_unit
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the 5-stage pipeline. It owns the PC, drives the synchronous instruction memory, and presents one instruction per cycle with its sequential next PC to the fetch/decode pipeline latch. It also absorbs hazard-unit stalls through a one-entry hold buffer, and it applies branch/jump redirects from execute with a fixed two-bubble penalty.

## Interface
- PC_WIDTH, 12, PC/instruction-address width; all PC arithmetic is modulo 2^PC_WIDTH
- INST_WIDTH, 32, instruction width
- RESET_PC, 0, first address fetched after reset
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state on the next rising edge
- stall  in  1  downstream latch not accepting this cycle (drives latch inEnabled low)
- redirect  in  1  taken branch/jump; squash wrong-path fetch and restart at redirectPc
- redirectPc  in  PC_WIDTH  redirect target
- imemAddr  out  PC_WIDTH  instruction-memory address; equal to pc register
- imemData  in  INST_WIDTH  instruction memory read data; one-cycle latency (data for the address presented in cycle n appears in cycle n+1)
- inst  out  INST_WIDTH  instruction offered to the F/D latch; all-zero (nop) whenever fetchValid=0
- seqNextPc  out  PC_WIDTH  outPc+1, wrapping
- fetchValid  out  1  inst is a real instruction

## Operation
- Registers: pc (next address to issue), respPc/respValid (address whose data is on imemData this cycle), holdInst/holdPc/holdValid (one-entry buffer).
- Output select: holdValid ? (holdInst, holdPc) : (imemData, respPc); fetchValid = holdValid | respValid, forced 0 in any cycle with redirect=1.
- Transfer = fetchValid & !stall.
- advance = !(stall & (holdValid | respValid)); when advance: respPc<=pc, respValid<=1, pc<=pc+1; else respValid<=0, pc held.
- capture: respValid & stall & !holdValid -> holdInst<=imemData, holdPc<=respPc, holdValid<=1.
- release: holdValid & !stall -> holdValid<=0 (concurrent with advance).
- Implicit states: EMPTY (respValid=0, holdValid=0), STREAM (respValid=1), HELD (holdValid=1). Transitions: EMPTY->STREAM on any non-reset cycle. STREAM->STREAM if !stall. STREAM->HELD if stall. HELD->HELD if stall. HELD->STREAM if !stall.
- Priority: reset > redirect > stall/advance logic.
- On redirect: pc<=redirectPc, respValid<=0, holdValid<=0, whatever the stall value.
- Reset values: pc=RESET_PC, respPc=0, respValid=0, holdValid=0, holdPc=0, holdInst=0. Outputs during and after reset: fetchValid=0, inst=0, imemAddr=RESET_PC.

## Timing
- Reset deasserted before edge c0. In c0, imemAddr=RESET_PC and fetchValid=0. In c1, inst=mem[RESET_PC] and seqNextPc=RESET_PC+1.
- Steady state: one instruction per cycle, with no bubbles across a stall release.
- Redirect asserted in cycle r: fetchValid=0 in r and r+1. In r+2, inst=mem[redirectPc].
- Stall: the output instruction is held stable, same inst/seqNextPc every stalled cycle. The in-flight response is never lost.
- Wrap-around: pc=2^PC_WIDTH-1 increments to 0. For outPc=4095, seqNextPc=0.
- Reset mid-HELD or mid-redirect discards everything; the behaviour is identical to power-up.

## Structure
- Shared header holds PC_WIDTH, INST_WIDTH, RESET_PC, and NOP_INST=0. The decode/F-D latch uses the same constants.
- One sub-module: fetch_hold_buffer, the holdInst/holdPc/holdValid register with capture/release/flush inputs.
- The PC register, response tracking and output mux live in fetch_unit.

## Test plan
- Free run after reset, mem[a]=0xA000_0000|a: c0 fetchValid=0 and inst=0. c1 inst=0xA0000000, seqNextPc=1. c2 inst=0xA0000001.
- Stall for 3 cycles while inst=mem[5]: inst=mem[5] and seqNextPc=6 for all 4 cycles, imemAddr=6 throughout. After release: mem[6], mem[7], with no bubble.
- redirect=1 with redirectPc=0x100 mid-stream: fetchValid=0 for 2 cycles. Next cycle inst=mem[0x100], seqNextPc=0x101.
- Redirect while HELD with stall=1: hold dropped and imemAddr=redirectPc next cycle. After the stall drops, the first valid inst=mem[redirectPc]. The held instruction never reappears.
- redirectPc=0xFFF: inst=mem[0xFFF] with seqNextPc=0x000, then inst=mem[0x000].
- reset=1 while HELD: next cycle fetchValid=0, inst=0, imemAddr=0. The normal power-up sequence follows.
